fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V pipeline: owns the PC, issues word requests to instruction memory, buffers returned instructions, and presents them with their PC and opcode field to the decode/immediate-generation stage. Handles redirects from branch/jump resolution by discarding in-flight and buffered stale instructions. Sits between instruction memory and decode.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_buffer.sv | 72 +++++++
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the reset PC default, NOP encoding, FSM states and buffer entry layout.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_2000;
    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
    localparam int          OPC_W        = 7;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] insn);
        return insn[OPC_W-1:0];
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: small synchronous FIFO of {pc, data} fetch entries.
// clear_i empties it in one cycle and overrides any push/pop that cycle.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  fetch_entry_t  push_entry_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Qualify push/pop against occupancy and compute next pointers.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: RESET_PC_DEF, data: NOP_INSN};
            end
        end else if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem requester and instruction buffer for decode.
// Build option FETCH_PERF_CNT_EN enables the perf_fetched/perf_dropped counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_data,
    output logic [31:0]      inst_pc,
    output logic [OPC_W-1:0] inst_opcode,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_dropped
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic               up_q;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    fetch_state_e       state_q, state_d;
    logic               discard;

    logic [CNT_W-1:0]   buf_count;
    fetch_entry_t       buf_head;
    fetch_entry_t       buf_entry;
    logic               buf_push;
    logic               buf_pop;

    logic [CNT_W:0]     occupancy;
    logic               credit_ok;
    logic               req_fire;
    logic               resp_fire;
    logic               resp_drop;

    // Handshakes and credit; a same-cycle pop frees its slot so a
    // 1-cycle memory can stream one instruction per cycle.
    always_comb begin
        buf_pop   = inst_valid && inst_ready;
        resp_fire = imem_resp_valid && (inflight_q != '0);
        resp_drop = resp_fire && discard;
        buf_push  = resp_fire && !resp_drop && !redirect_valid;
        occupancy = {1'b0, inflight_q} + {1'b0, buf_count}
                  - (CNT_W+1)'(buf_pop);
        credit_ok = occupancy < (CNT_W+1)'(BUF_DEPTH);
        req_fire  = imem_req_valid && imem_req_ready;
        buf_entry.data = imem_resp_data;
        buf_entry.pc   = pc_q - {{(30-CNT_W){1'b0}}, inflight_q, 2'b00};
    end

    // Next PC, outstanding count and stale-response count.
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
        drop_d     = drop_q - CNT_W'(resp_drop);
        if (redirect_valid) begin
            pc_d   = word_align(redirect_pc);
            drop_d = inflight_q - CNT_W'(resp_fire);
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Datapath registers; up_q holds off requests until after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q       <= 1'b0;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            up_q       <= 1'b1;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: DRAIN while stale responses remain outstanding.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_valid && (drop_d != '0)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drop_d == '0) state_d = ST_RUN;
            end
        endcase
    end

    // FSM outputs: responses are discarded while draining.
    always_comb begin
        discard = (state_q == ST_DRAIN);
    end

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (redirect_valid),
        .push_i      (buf_push),
        .push_entry_i(buf_entry),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .count_o     (buf_count)
    );

    assign imem_req_valid = up_q && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (buf_count != '0);
    assign inst_data      = inst_valid ? buf_head.data : NOP_INSN;
    assign inst_pc        = inst_valid ? buf_head.pc : RESET_PC;
    assign inst_opcode    = opcode_of(inst_data);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] dropped_q;

    // Delivered and discarded instruction counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(buf_pop);
            dropped_q <= dropped_q + 32'(resp_drop);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_dropped = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: vector table, directed corner sequences and
// random traffic against an epoch-tagged memory and stream model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_2000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [6:0]  inst_opcode;
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode),
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        bit          rqr;
        bit          ir;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_iv;
        logic [31:0] exp_ipc;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          epoch = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_fire = 0;
    bit          prev_rv = 0;
    mreq_t       mq[$];
    logic [31:0] deliv_q[$];
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_req = RST_PC;
    logic [31:0] m_fetched = 0;
    logic [31:0] m_dropped = 0;
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_inst_valid;
    logic [31:0] s_inst_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        deliv_q.delete();
        exp_pc    = RST_PC;
        exp_req   = RST_PC;
        m_fetched = 0;
        m_dropped = 0;
        prev_rv   = 0;
        last_due  = cyc;
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        inst_ready      = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, NOP);
        chk("rst_inst_pc", inst_pc, RST_PC);
        chk("rst_opcode", inst_opcode, 7'h13);
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_dropped", perf_dropped, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs after a negedge, sample #1 later, update model.
    task automatic cycle(input bit rqr, input bit ir, input bit rv,
                         input logic [31:0] rpc);
        mreq_t r;
        bit    got;
        int    due;
        imem_req_ready = rqr;
        inst_ready     = ir;
        redirect_valid = rv;
        redirect_pc    = rpc;
        got = 0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            got = 1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(r.addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_dropped", perf_dropped, m_dropped);
`else
        chk("perf_fetched_off", perf_fetched, 0);
        chk("perf_dropped_off", perf_dropped, 0);
`endif
        if (prev_rv) chk("flush_inst_valid", inst_valid, 0);
        if (inst_valid) chk("opcode", inst_opcode, inst_data[6:0]);
        else chk("idle_nop", inst_data, NOP);
        if (inst_valid && ir) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem_word(exp_pc));
            deliv_q.push_back(inst_pc);
            exp_pc    = exp_pc + 32'd4;
            m_fetched = m_fetched + 32'd1;
        end
        if (got && r.epoch != epoch) m_dropped = m_dropped + 32'd1;
        if (rv) chk("redirect_no_req", imem_req_valid, 0);
        if (imem_req_valid && rqr) begin
            chk("req_addr", imem_req_addr, exp_req);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            mq.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
            last_due = due;
            exp_req  = exp_req + 32'd4;
            n_fire++;
            chk("credit", 32'(mq.size() <= BUF_DEPTH), 1);
        end
        if (rv) begin
            epoch++;
            exp_pc  = rpc & 32'hFFFF_FFFC;
            exp_req = rpc & 32'hFFFF_FFFC;
        end
        prev_rv = rv;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [31:0] first_deliv();
        return (deliv_q.size() > 0) ? deliv_q[0] : 32'hDEAD_BEEF;
    endfunction

    vec_t vecs[6];

    initial begin
        int n0;
        logic [31:0] rpc;
        vecs[0] = '{1, 1, 0, 32'h2000, 0, 32'h0};
        vecs[1] = '{1, 1, 1, 32'h2000, 0, 32'h0};
        vecs[2] = '{1, 1, 1, 32'h2004, 0, 32'h0};
        vecs[3] = '{1, 1, 1, 32'h2008, 1, 32'h2000};
        vecs[4] = '{1, 1, 1, 32'h200C, 1, 32'h2004};
        vecs[5] = '{1, 1, 1, 32'h2010, 1, 32'h2008};

        @(negedge clk);
        apply_reset();

        // Reset release with 1-cycle memory streaming.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].rqr, vecs[i].ir, 0, 32'd0);
            chk($sformatf("vec%0d_req_valid", i), s_req_valid, vecs[i].exp_rv);
            chk($sformatf("vec%0d_req_addr", i), s_req_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_inst_valid", i), s_inst_valid, vecs[i].exp_iv);
            if (vecs[i].exp_iv)
                chk($sformatf("vec%0d_inst_pc", i), s_inst_pc, vecs[i].exp_ipc);
        end

        // Decode stall: requests stop once buffer credit is used up.
        n0 = n_fire;
        repeat (5) cycle(1, 0, 0, 32'd0);
        chk("stall_reqs_le2", 32'((n_fire - n0) <= 2), 1);
        chk("stall_req_valid", s_req_valid, 0);
        repeat (10) cycle(1, 1, 0, 32'd0);

        // Unaligned redirect target is fetched word aligned.
        cycle(1, 1, 1, 32'h0000_3003);
        cycle(1, 1, 0, 32'd0);
        chk("unaligned_req_valid", s_req_valid, 1);
        chk("unaligned_req_addr", s_req_addr, 32'h3000);
        repeat (6) cycle(1, 1, 0, 32'd0);

        // Redirect with two requests in flight on a 3-cycle memory.
        apply_reset();
        lat_min = 3; lat_max = 3;
        repeat (3) cycle(1, 1, 0, 32'd0);
        chk("drain_inflight", mq.size(), 2);
        cycle(1, 1, 1, 32'h3000);
        repeat (15) cycle(1, 1, 0, 32'd0);
        chk("drain_first_pc", first_deliv(), 32'h3000);
`ifdef FETCH_PERF_CNT_EN
        chk("drain_perf_dropped", perf_dropped, 2);
`endif

        // Back-to-back redirects while draining.
        repeat (6) cycle(1, 1, 0, 32'd0);
        cycle(1, 1, 1, 32'h4000);
        deliv_q.delete();
        cycle(1, 1, 1, 32'h5000);
        repeat (20) cycle(1, 1, 0, 32'd0);
        chk("b2b_first_pc", first_deliv(), 32'h5000);

        // Reset pulse mid-stream.
        lat_min = 1; lat_max = 2;
        repeat (8) cycle(1, 1, 0, 32'd0);
        apply_reset();
        repeat (8) cycle(1, 1, 0, 32'd0);
        chk("rst_restart_pc", first_deliv(), 32'h2000);

        // Random traffic against the stream model.
        lat_min = 1; lat_max = 4;
        m_fetched = m_fetched;
        n0 = int'(m_fetched);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0)
                rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                rpc = $urandom;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3, rpc);
        end
        chk("random_progress", 32'((int'(m_fetched) - n0) > 200), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
